// File: rtl/ret_stack.sv
// Return-address LIFO with registered pop output and a sticky overflow/underflow flag.
// Define RET_STACK_WRAP_EN to make a push on a full stack overwrite the oldest entry instead of dropping it.
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [0:WIDTH-1]         push_data,
    input  logic                     pop,
    input  logic                     err_clr,
    output logic [0:WIDTH-1]         pop_data,
    output logic                     pop_valid,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);

`ifdef RET_STACK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [0:WIDTH-1] mem [DEPTH];
    // top_reg is the next free slot; the live top entry sits one below it (modulo DEPTH)
    logic [AW-1:0] top_reg;
    logic [AW-1:0] top_next;
    logic [AW-1:0] top_idx;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;

    logic swap;
    logic pop_only;
    logic push_only;
    logic push_write;
    logic underflow;
    logic overflow;
    logic take;

    assign top_idx = top_reg - ONE_PTR;
    assign depth   = count_reg;

    always_comb begin
        swap       = push && pop && !empty;
        pop_only   = pop && !push && !empty;
        push_only  = push && (!pop || empty);
        underflow  = pop && empty;
        overflow   = push_only && full;
        push_write = push_only && (!full || WRAP_EN);
        take       = swap || pop_only;

        top_next   = top_reg;
        count_next = count_reg;
        if (pop_only) begin
            top_next   = top_reg - ONE_PTR;
            count_next = count_reg - ONE_CNT;
        end else if (push_write) begin
            top_next = top_reg + ONE_PTR;
            // a wrapping push on a full stack advances the ring but keeps the count at DEPTH
            if (!full) begin
                count_next = count_reg + ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg   <= '0;
            count_reg <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            err       <= 1'b0;
        end else begin
            top_reg   <= top_next;
            count_reg <= count_next;
            full      <= (count_next == FULL_COUNT);
            empty     <= (count_next == '0);
            pop_valid <= take;
            if (take) begin
                pop_data <= mem[top_idx];
            end
            if (underflow || overflow) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // Storage is not reset; entries beyond the count are never observable.
    always_ff @(posedge clk) begin
        if (swap) begin
            mem[top_idx] <= push_data;
        end else if (push_write) begin
            mem[top_reg] <= push_data;
        end
    end

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: a queue-based LIFO model checked every cycle plus literal expectations.
module tb_ret_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

`ifdef RET_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             err_clr = 1'b0;
    logic [0:WIDTH-1] push_data = '0;
    logic [0:WIDTH-1] pop_data;
    logic             pop_valid;
    logic [3:0]       depth;
    logic             full;
    logic             empty;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [15:0] stk[$];
    logic [15:0] m_pd = '0;
    bit          m_pv = 1'b0;
    bit          m_err = 1'b0;

    ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .err_clr(err_clr), .pop_data(pop_data), .pop_valid(pop_valid),
        .depth(depth), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the stack rules: top of stack is the back of the queue, oldest is the front.
    task automatic model_step(input bit p, input logic [15:0] d, input bit q, input bit c);
        bit ev = 1'b0;
        int n = stk.size();
        m_pv = 1'b0;
        if (q && p && n > 0) begin
            m_pd = stk[n-1];
            stk[n-1] = d;
            m_pv = 1'b1;
        end else if (q && !p && n > 0) begin
            m_pd = stk.pop_back();
            m_pv = 1'b1;
        end else begin
            if (q) ev = 1'b1;
            if (p) begin
                if (n < DEPTH) begin
                    stk.push_back(d);
                end else begin
                    ev = 1'b1;
                    if (WRAP) begin
                        void'(stk.pop_front());
                        stk.push_back(d);
                    end
                end
            end
        end
        if (ev) m_err = 1'b1;
        else if (c) m_err = 1'b0;
    endtask

    task automatic cycle(input bit p, input logic [15:0] d, input bit q, input bit c);
        push = p; push_data = d; pop = q; err_clr = c;
        @(posedge clk);
        #1;
        model_step(p, d, q, c);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        $display("txn push=%0b data=%h pop=%0b clr=%0b -> depth=%0d pop_valid=%0b pop_data=%h err=%0b",
                 p, d, q, c, depth, pop_valid, pop_data, err);
    endtask

    always @(negedge clk) begin
        chk("cyc_depth", 32'(depth), 32'(stk.size()));
        chk("cyc_full", 32'(full), 32'(stk.size() == DEPTH));
        chk("cyc_empty", 32'(empty), 32'(stk.size() == 0));
        chk("cyc_pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("cyc_pop_data", 32'(pop_data), 32'(m_pd));
        chk("cyc_err", 32'(err), 32'(m_err));
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        rst = 1'b0;

        // LIFO order with one-cycle pop latency
        cycle(1, 16'h0100, 0, 0);
        cycle(1, 16'h0200, 0, 0);
        cycle(1, 16'h0300, 0, 0);
        chk("lifo_depth3", 32'(depth), 32'd3);
        cycle(0, 16'h0, 1, 0);
        chk("lifo_pop1", 32'(pop_data), 32'h0300);
        chk("lifo_pv1", 32'(pop_valid), 32'd1);
        cycle(0, 16'h0, 1, 0);
        chk("lifo_pop2", 32'(pop_data), 32'h0200);
        cycle(0, 16'h0, 1, 0);
        chk("lifo_pop3", 32'(pop_data), 32'h0100);
        cycle(0, 16'h0, 0, 0);
        chk("lifo_empty", 32'(empty), 32'd1);
        chk("lifo_pv_low", 32'(pop_valid), 32'd0);

        // Simultaneous push and pop on a non-empty stack
        cycle(1, 16'h0090, 0, 0);
        cycle(1, 16'h00A0, 0, 0);
        cycle(1, 16'h00B0, 1, 0);
        chk("swap_pop_data", 32'(pop_data), 32'h00A0);
        chk("swap_pv", 32'(pop_valid), 32'd1);
        chk("swap_depth", 32'(depth), 32'd2);
        cycle(0, 16'h0, 1, 0);
        chk("swap_next_pop", 32'(pop_data), 32'h00B0);
        cycle(0, 16'h0, 1, 0);
        chk("swap_last_pop", 32'(pop_data), 32'h0090);

        // Underflow
        cycle(0, 16'h0, 1, 0);
        chk("uf_pv", 32'(pop_valid), 32'd0);
        chk("uf_pop_data", 32'(pop_data), 32'h0090);
        chk("uf_err", 32'(err), 32'd1);
        cycle(0, 16'h0, 0, 1);
        chk("uf_err_clr", 32'(err), 32'd0);

        // Push and pop together on an empty stack
        cycle(1, 16'h1234, 1, 0);
        chk("pe_depth", 32'(depth), 32'd1);
        chk("pe_pv", 32'(pop_valid), 32'd0);
        chk("pe_err", 32'(err), 32'd1);
        cycle(0, 16'h0, 0, 1);
        cycle(0, 16'h0, 1, 0);
        chk("pe_pop", 32'(pop_data), 32'h1234);

        // Fill, overflow (set wins over a coincident clear), then drain
        for (int i = 1; i <= 8; i++) cycle(1, 16'(i), 0, 0);
        chk("of_full", 32'(full), 32'd1);
        cycle(1, 16'h0009, 0, 1);
        chk("of_err", 32'(err), 32'd1);
        chk("of_depth", 32'(depth), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 16'h0, 1, 0);
            chk("of_drain", 32'(pop_data), WRAP ? 32'(9 - i) : 32'(8 - i));
        end
        chk("of_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-run with depth 3; the push held across the reset edge is discarded
        cycle(1, 16'h0A0A, 0, 0);
        cycle(1, 16'h0B0B, 0, 0);
        cycle(1, 16'h0C0C, 0, 0);
        #2;
        rst = 1'b1;
        push = 1'b1;
        push_data = 16'hDEAD;
        #1;
        chk("ar_depth", 32'(depth), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        chk("ar_pv", 32'(pop_valid), 32'd0);
        chk("ar_pop_data", 32'(pop_data), 32'd0);
        stk.delete();
        m_pd = '0;
        m_pv = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push = 1'b0;
        chk("ar_discard", 32'(depth), 32'd0);
        cycle(1, 16'h5555, 0, 0);
        cycle(0, 16'h0, 1, 0);
        chk("ar_resume", 32'(pop_data), 32'h5555);
        cycle(0, 16'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
